// File: rtl/edge_event_arbiter.sv
// ---------------------------------------------------------------------------
// edge_event_arbiter
//
// Multi-channel edge-event scheduler. Each asynchronous level input goes
// through a synchronizer and a dual-edge detector. A detected edge is held as
// a pending event. A round-robin arbiter serializes the pending events onto a
// single valid/ready port that carries the channel index and the edge
// polarity.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-high reset
//   level        raw asynchronous level inputs, one bit per channel
//   enable       per-channel event enable (synchronous to clk)
//   ev_valid     an event is being presented on ev_ch / ev_rise
//   ev_ready     consumer accepts the event when high together with ev_valid
//   ev_ch        channel index of the presented event
//   ev_rise      1 = rising edge, 0 = falling edge
//   overrun      sticky per-channel flag: an edge was dropped
//   clr_overrun  synchronous clear of all overrun bits (a new set wins)
// ---------------------------------------------------------------------------
module edge_event_arbiter #(
    parameter int N_CH        = 4,
    parameter int ID_W        = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] level,
    input  logic [N_CH-1:0] enable,
    output logic            ev_valid,
    input  logic            ev_ready,
    output logic [ID_W-1:0] ev_ch,
    output logic            ev_rise,
    output logic [N_CH-1:0] overrun,
    input  logic            clr_overrun
);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } state_t;

    // Channel reached after stepping 'step' positions past 'last', modulo N_CH.
    function automatic logic [ID_W-1:0] rr_idx(input logic [ID_W-1:0] last,
                                               input int step);
        int v;
        v = (int'(last) + step) % N_CH;
        return ID_W'(v);
    endfunction

    logic [N_CH-1:0] sync_r [SYNC_STAGES];
    logic [N_CH-1:0] prev_r;
    logic [N_CH-1:0] pending_r;
    logic [N_CH-1:0] pending_pol_r;
    logic [N_CH-1:0] overrun_r;
    logic [N_CH-1:0] sync_out_s;
    logic [N_CH-1:0] edge_s;
    logic [N_CH-1:0] take_s;
    logic [N_CH-1:0] ovr_set_s;
    logic            sel_found_s;
    logic [ID_W-1:0] sel_idx_s;
    logic            load_s;

    state_t          state_r;
    logic            ev_valid_r;
    logic [ID_W-1:0] ev_ch_r;
    logic            ev_rise_r;
    logic [ID_W-1:0] last_grant_r;

    assign ev_valid = ev_valid_r;
    assign ev_ch    = ev_ch_r;
    assign ev_rise  = ev_rise_r;
    assign overrun  = overrun_r;

    assign sync_out_s = sync_r[SYNC_STAGES-1];
    assign edge_s     = sync_out_s ^ prev_r;

    // Synchronizer chain for all channels.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_r[s] <= '0;
            end
        end else begin
            sync_r[0] <= level;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_r[s] <= sync_r[s-1];
            end
        end
    end

    // Round-robin pick: first pending channel after last_grant, wrapping.
    always_comb begin
        sel_found_s = 1'b0;
        sel_idx_s   = '0;
        for (int i = 1; i <= N_CH; i++) begin
            sel_idx_s   = (!sel_found_s && pending_r[rr_idx(last_grant_r, i)])
                          ? rr_idx(last_grant_r, i) : sel_idx_s;
            sel_found_s = sel_found_s | pending_r[rr_idx(last_grant_r, i)];
        end
    end

    // A load happens whenever something is pending and the output slot is free
    // (idle) or is being emptied by a handshake this cycle.
    assign load_s = sel_found_s && ((state_r == ST_IDLE) || (ev_ready == 1'b1));

    // Per-channel take strobe and overrun detection.
    always_comb begin
        take_s    = '0;
        ovr_set_s = '0;
        for (int ch = 0; ch < N_CH; ch++) begin
            take_s[ch]    = load_s && (sel_idx_s == ID_W'(ch));
            ovr_set_s[ch] = enable[ch] && edge_s[ch] && pending_r[ch] && !take_s[ch];
        end
    end

    // Edge history, pending events and sticky overrun flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_r        <= '0;
            pending_r     <= '0;
            pending_pol_r <= '0;
            overrun_r     <= '0;
        end else begin
            prev_r    <= sync_out_s;
            overrun_r <= (overrun_r & ~{N_CH{clr_overrun}}) | ovr_set_s;
            for (int ch = 0; ch < N_CH; ch++) begin
                if (!enable[ch]) begin
                    pending_r[ch] <= 1'b0;
                end else if (edge_s[ch] && (!pending_r[ch] || take_s[ch])) begin
                    // Slot is free, or is vacated by the arbiter this cycle.
                    pending_r[ch]     <= 1'b1;
                    pending_pol_r[ch] <= sync_out_s[ch];
                end else if (take_s[ch]) begin
                    pending_r[ch] <= 1'b0;
                end else begin
                    // Older pending event (if any) is kept untouched.
                    pending_r[ch] <= pending_r[ch];
                end
            end
        end
    end

    // Arbiter FSM with registered event outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            ev_valid_r   <= 1'b0;
            ev_ch_r      <= '0;
            ev_rise_r    <= 1'b0;
            last_grant_r <= ID_W'(N_CH - 1);
        end else begin
            if (load_s) begin
                ev_ch_r      <= sel_idx_s;
                ev_rise_r    <= pending_pol_r[sel_idx_s];
                last_grant_r <= sel_idx_s;
            end else begin
                ev_ch_r      <= ev_ch_r;
                ev_rise_r    <= ev_rise_r;
                last_grant_r <= last_grant_r;
            end
            case (state_r)
                ST_IDLE: begin
                    if (sel_found_s) begin
                        state_r    <= ST_PRESENT;
                        ev_valid_r <= 1'b1;
                    end else begin
                        state_r    <= ST_IDLE;
                        ev_valid_r <= 1'b0;
                    end
                end
                ST_PRESENT: begin
                    if (ev_ready && !sel_found_s) begin
                        state_r    <= ST_IDLE;
                        ev_valid_r <= 1'b0;
                    end else begin
                        state_r    <= ST_PRESENT;
                        ev_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    ev_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// ---------------------------------------------------------------------------
// tb_edge_event_arbiter
//
// Randomized stimulus against a behavioural reference model of the edge
// event scheduler, plus a few directed checks (first-event latency, reset
// values, asynchronous reset while an event is presented).
// ---------------------------------------------------------------------------
module tb_edge_event_arbiter;

    localparam int N  = 4;
    localparam int IW = 2;
    localparam int S  = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  level;
    logic [N-1:0]  enable;
    logic          ev_ready;
    logic          clr_overrun;
    logic          ev_valid;
    logic [IW-1:0] ev_ch;
    logic          ev_rise;
    logic [N-1:0]  overrun;

    edge_event_arbiter #(.N_CH(N), .ID_W(IW), .SYNC_STAGES(S)) dut (
        .clk         (clk),
        .reset       (reset),
        .level       (level),
        .enable      (enable),
        .ev_valid    (ev_valid),
        .ev_ready    (ev_ready),
        .ev_ch       (ev_ch),
        .ev_rise     (ev_rise),
        .overrun     (overrun),
        .clr_overrun (clr_overrun)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    // Single comparison point for the whole bench.
    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Synchronized view of a channel = the level that was applied S clock
    // edges earlier; kept as a queue of past level samples.
    bit [N-1:0] hist_q[$];
    int         seen[N];      // last synchronized value seen per channel
    int         pend[N];      // 1 = an event is waiting
    int         pol[N];       // polarity of the waiting event
    int         ovr[N];
    int         out_valid;
    int         out_ch;
    int         out_rise;
    int         last_ch;

    task automatic model_reset();
        hist_q.delete();
        for (int k = 0; k < S; k++) hist_q.push_back('0);
        for (int c = 0; c < N; c++) begin
            seen[c] = 0; pend[c] = 0; pol[c] = 0; ovr[c] = 0;
        end
        out_valid = 0; out_ch = 0; out_rise = 0; last_ch = N - 1;
    endtask

    // One rising clock edge using the inputs currently applied.
    task automatic model_step();
        int syn[N];
        int edg[N];
        int pick;
        int do_load;
        bit [N-1:0] oldest;
        oldest = hist_q.pop_front();
        hist_q.push_back(level);
        for (int c = 0; c < N; c++) begin
            syn[c] = oldest[c];
            edg[c] = (syn[c] != seen[c]) ? 1 : 0;
        end
        pick = -1;
        for (int i = 1; i <= N; i++) begin
            int c;
            c = (last_ch + i) % N;
            if (pick < 0 && pend[c] == 1) pick = c;
        end
        do_load = (pick >= 0 && (out_valid == 0 || ev_ready == 1'b1)) ? 1 : 0;
        if (do_load == 1) begin
            out_valid = 1; out_ch = pick; out_rise = pol[pick]; last_ch = pick;
            pend[pick] = 0;
        end else if (out_valid == 1 && ev_ready == 1'b1) begin
            out_valid = 0;
        end
        for (int c = 0; c < N; c++) begin
            if (clr_overrun == 1'b1) ovr[c] = 0;
            if (enable[c] == 1'b0) begin
                pend[c] = 0;
            end else if (edg[c] == 1) begin
                // after a take the slot for this channel is already free
                if (pend[c] == 0) begin
                    pend[c] = 1; pol[c] = syn[c];
                end else begin
                    ovr[c] = 1;
                end
            end
            seen[c] = syn[c];
        end
    endtask

    task automatic check_outputs();
        bit [N-1:0] ov_exp;
        for (int c = 0; c < N; c++) ov_exp[c] = ovr[c][0];
        check_val("ev_valid", ev_valid, out_valid);
        check_val("ev_ch",    ev_ch,    out_ch);
        check_val("ev_rise",  ev_rise,  out_rise);
        check_val("overrun",  overrun,  ov_exp);
    endtask

    // Advance one clock; compare just after the edge.
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, "_valid"}, ev_valid, 0);
        check_val({tag, "_ch"},    ev_ch,    0);
        check_val({tag, "_rise"},  ev_rise,  0);
        check_val({tag, "_ovr"},   overrun,  0);
    endtask

    int first_k;
    int tog, rdy_p, clr_p, en_p;
    int waited;

    initial begin
        reset = 1'b1; level = '0; enable = '1; ev_ready = 1'b0; clr_overrun = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("rst");
        reset = 1'b0;

        // Directed latency: level 0001 applied before edge 1, valid after edge 4.
        level = 4'b0001;
        first_k = 0;
        for (int k = 1; k <= 8; k++) begin
            cycle();
            if (first_k == 0 && ev_valid === 1'b1) begin
                first_k = k;
                check_val("lat_ch",   ev_ch,   0);
                check_val("lat_rise", ev_rise, 1);
            end
        end
        check_val("latency", first_k, 4);
        ev_ready = 1'b1;
        cycle();
        check_val("drain", ev_valid, 0);

        // Randomized phases with different stress profiles.
        for (int ph = 0; ph < 5; ph++) begin
            case (ph)
                0: begin tog = 10; rdy_p = 90; clr_p = 5;  en_p = 0;  end
                1: begin tog = 40; rdy_p = 20; clr_p = 10; en_p = 0;  end
                2: begin tog = 25; rdy_p = 50; clr_p = 15; en_p = 10; end
                3: begin tog = 60; rdy_p = 10; clr_p = 30; en_p = 5;  end
                default: begin tog = 20; rdy_p = 70; clr_p = 10; en_p = 20; end
            endcase
            for (int n = 0; n < 400; n++) begin
                for (int c = 0; c < N; c++) begin
                    if ($urandom_range(99) < tog) level[c] = ~level[c];
                    if ($urandom_range(99) < en_p) enable[c] = ~enable[c];
                end
                if (en_p == 0) enable = '1;
                ev_ready    = ($urandom_range(99) < rdy_p) ? 1'b1 : 1'b0;
                clr_overrun = ($urandom_range(99) < clr_p) ? 1'b1 : 1'b0;
                cycle();
            end
        end

        // Asynchronous reset while an event is presented.
        enable = '1; ev_ready = 1'b0; clr_overrun = 1'b0;
        waited = 0;
        while (ev_valid !== 1'b1 && waited < 50) begin
            level = level ^ N'($urandom_range(15));
            cycle();
            waited++;
        end
        check_val("pre_rst_valid", ev_valid, 1);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_reset_state("mid_rst");
        level = '0;
        repeat (2) begin
            @(posedge clk);
            #1;
            check_reset_state("hold_rst");
        end
        reset = 1'b0;
        for (int n = 0; n < 12; n++) cycle();
        check_val("no_stale", ev_valid, 0);

        // Short random tail after reset release.
        for (int n = 0; n < 200; n++) begin
            for (int c = 0; c < N; c++)
                if ($urandom_range(99) < 30) level[c] = ~level[c];
            ev_ready    = ($urandom_range(99) < 60) ? 1'b1 : 1'b0;
            clr_overrun = ($urandom_range(99) < 10) ? 1'b1 : 1'b0;
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
